// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep checker: FSM states, first-mismatch kinds and
// a width helper for channel-index ports.
package lockstep_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      WARMUP   = 2'd1,
      CHECKING = 2'd2,
      FAILED   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      VALID = 2'd1,
      DATA  = 2'd2
   } kind_t;

   localparam int MAX_SKEW = 15;
   localparam int WCNT_W   = 4;

   // A single-channel build still needs a 1-bit channel index port.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// Valid+data shift register of DEPTH stages; DEPTH=0 is a plain wire.
// Synchronous flush empties every stage; async active-low reset.
module lockstep_delay_line #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_dat_i,
   output logic         out_vld_o,
   output logic [W-1:0] out_dat_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign out_vld_o = in_vld_i;
         assign out_dat_o = in_dat_i;
      end else begin : g_pipe
         logic [DEPTH-1:0] vld_q;
         logic [W-1:0]     dat_q [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
               for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else if (flush_i) begin
               vld_q <= '0;
               for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else begin
               vld_q[0] <= in_vld_i;
               dat_q[0] <= in_dat_i;
               for (int i = 1; i < DEPTH; i++) begin
                  vld_q[i] <= vld_q[i-1];
                  dat_q[i] <= dat_q[i-1];
               end
            end
         end

         assign out_vld_o = vld_q[DEPTH-1];
         assign out_dat_o = dat_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/lockstep_checker.sv
// Clocked N_CHAN x W lockstep comparator: aligns ref to uut by SKEW cycles, counts
// mismatching/compared cycles and captures the first failure. Results registered (1 cycle).
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int                N_CHAN       = 4,
   parameter int                W            = 8,
   parameter int                SKEW         = 2,
   parameter logic [N_CHAN-1:0] CHAN_MASK    = '1,
   parameter int                STOP_ON_FAIL = 1,
   parameter int                CNT_W        = 16,
   localparam int               CHW          = clog2_min1(N_CHAN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  ref_valid,
   input  logic [N_CHAN*W-1:0]   ref_data,
   input  logic                  uut_valid,
   input  logic [N_CHAN*W-1:0]   uut_data,
   output logic                  err,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      mismatch_cnt,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [1:0]            first_kind,
   output logic [CHW-1:0]        first_chan,
   output logic [W-1:0]          first_ref,
   output logic [W-1:0]          first_uut,
   output logic [CNT_W-1:0]      first_cycle
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                  aref_valid;
   logic [N_CHAN*W-1:0]   aref_data;

   lockstep_delay_line #(
      .DEPTH (SKEW),
      .W     (N_CHAN*W)
   ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (clr | ~en),
      .in_vld_i  (ref_valid),
      .in_dat_i  (ref_data),
      .out_vld_o (aref_valid),
      .out_dat_o (aref_data)
   );

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    mcnt_q, mcnt_d;
   logic [CNT_W-1:0]    ccnt_q, ccnt_d;
   kind_t               fkind_q, fkind_d;
   logic [CHW-1:0]      fchan_q, fchan_d;
   logic [W-1:0]        fref_q, fref_d;
   logic [W-1:0]        fuut_q, fuut_d;
   logic [CNT_W-1:0]    fcyc_q, fcyc_d;

   logic                do_cmp;
   logic [N_CHAN-1:0]   chan_diff;
   logic                vld_mm;
   logic                dat_mm;
   logic                mm;
   logic [CHW-1:0]      fail_chan;
   logic [W-1:0]        sel_ref;
   logic [W-1:0]        sel_uut;

   // A same-cycle clr or !en suppresses the compare outright.
   assign do_cmp = en & ~clr & (state_q == CHECKING);

   always_comb begin
      chan_diff = '0;
      for (int i = 0; i < N_CHAN; i++) begin
         chan_diff[i] = CHAN_MASK[i] && (aref_data[i*W +: W] != uut_data[i*W +: W]);
      end
   end

   assign vld_mm = aref_valid ^ uut_valid;
   assign dat_mm = aref_valid & uut_valid & (|chan_diff);
   assign mm     = do_cmp & (vld_mm | dat_mm);

   // Lowest failing channel wins; a VALID mismatch always reports channel 0.
   always_comb begin
      fail_chan = '0;
      for (int i = N_CHAN - 1; i >= 0; i--) begin
         if (chan_diff[i]) fail_chan = CHW'(i);
      end
      if (vld_mm) fail_chan = '0;
   end

   always_comb begin
      sel_ref = '0;
      sel_uut = '0;
      for (int i = 0; i < N_CHAN; i++) begin
         if (CHW'(i) == fail_chan) begin
            sel_ref = aref_data[i*W +: W];
            sel_uut = uut_data[i*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      if (!en) begin
         state_d = DISABLED;
      end else if (clr) begin
         state_d = (SKEW == 0) ? CHECKING : WARMUP;
         wcnt_d  = '0;
      end else begin
         case (state_q)
            DISABLED: begin
               state_d = (SKEW == 0) ? CHECKING : WARMUP;
               wcnt_d  = '0;
            end
            WARMUP: begin
               if (wcnt_q == WCNT_W'(SKEW - 1)) state_d = CHECKING;
               else                             wcnt_d  = wcnt_q + 4'd1;
            end
            CHECKING: begin
               if (mm && (STOP_ON_FAIL != 0)) state_d = FAILED;
            end
            FAILED:   state_d = FAILED;
            default:  state_d = DISABLED;
         endcase
      end
   end

   always_comb begin
      err_d   = err_q;
      mcnt_d  = mcnt_q;
      ccnt_d  = ccnt_q;
      fkind_d = fkind_q;
      fchan_d = fchan_q;
      fref_d  = fref_q;
      fuut_d  = fuut_q;
      fcyc_d  = fcyc_q;
      if (clr) begin
         err_d   = 1'b0;
         mcnt_d  = '0;
         ccnt_d  = '0;
         fkind_d = NONE;
         fchan_d = '0;
         fref_d  = '0;
         fuut_d  = '0;
         fcyc_d  = '0;
      end else if (do_cmp) begin
         ccnt_d = (ccnt_q == '1) ? ccnt_q : ccnt_q + CNT_ONE;
         if (mm) begin
            err_d  = 1'b1;
            mcnt_d = (mcnt_q == '1) ? mcnt_q : mcnt_q + CNT_ONE;
            if (fkind_q == NONE) begin
               fkind_d = vld_mm ? VALID : DATA;
               fchan_d = fail_chan;
               fref_d  = sel_ref;
               fuut_d  = sel_uut;
               fcyc_d  = ccnt_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DISABLED;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
         mcnt_q  <= '0;
         ccnt_q  <= '0;
         fkind_q <= NONE;
         fchan_q <= '0;
         fref_q  <= '0;
         fuut_q  <= '0;
         fcyc_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         mcnt_q  <= mcnt_d;
         ccnt_q  <= ccnt_d;
         fkind_q <= fkind_d;
         fchan_q <= fchan_d;
         fref_q  <= fref_d;
         fuut_q  <= fuut_d;
         fcyc_q  <= fcyc_d;
      end
   end

   assign err          = err_q;
   assign state        = state_q;
   assign mismatch_cnt = mcnt_q;
   assign cycle_cnt    = ccnt_q;
   assign first_kind   = fkind_q;
   assign first_chan   = fchan_q;
   assign first_ref    = fref_q;
   assign first_uut    = fuut_q;
   assign first_cycle  = fcyc_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench: two checkers share one stimulus; A stops on fail with all channels
// compared, B keeps counting with channel 0 masked off.
module tb_lockstep_checker;

   logic        clk = 1'b0;
   logic        rst_n, en, clr;
   logic        ref_valid, uut_valid;
   logic [31:0] ref_data, uut_data;

   logic        a_err, b_err;
   logic [1:0]  a_state, b_state, a_kind, b_kind, a_chan, b_chan;
   logic [15:0] a_mcnt, b_mcnt, a_ccnt, b_ccnt, a_fcyc, b_fcyc;
   logic [7:0]  a_fref, b_fref, a_fuut, b_fuut;

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;

   logic        hv1 = 1'b0, hv2 = 1'b0;
   logic [31:0] hd1 = '0, hd2 = '0;
   logic [7:0]  exp_ref;

   always #5 clk = ~clk;

   lockstep_checker #(
      .N_CHAN(4), .W(8), .SKEW(2), .CHAN_MASK(4'b1111), .STOP_ON_FAIL(1), .CNT_W(16)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .ref_valid(ref_valid), .ref_data(ref_data),
      .uut_valid(uut_valid), .uut_data(uut_data),
      .err(a_err), .state(a_state), .mismatch_cnt(a_mcnt), .cycle_cnt(a_ccnt),
      .first_kind(a_kind), .first_chan(a_chan), .first_ref(a_fref),
      .first_uut(a_fuut), .first_cycle(a_fcyc)
   );

   lockstep_checker #(
      .N_CHAN(4), .W(8), .SKEW(2), .CHAN_MASK(4'b1110), .STOP_ON_FAIL(0), .CNT_W(16)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .ref_valid(ref_valid), .ref_data(ref_data),
      .uut_valid(uut_valid), .uut_data(uut_data),
      .err(b_err), .state(b_state), .mismatch_cnt(b_mcnt), .cycle_cnt(b_ccnt),
      .first_kind(b_kind), .first_chan(b_chan), .first_ref(b_fref),
      .first_uut(b_fuut), .first_cycle(b_fcyc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int n);
      logic [7:0] b;
      b = 8'(n);
      return {b ^ 8'hC3, b + 8'd17, ~b, b};
   endfunction

   // Drives one cycle: uut replays the ref beat from two cycles earlier, optionally
   // corrupted (xm) or with its valid dropped; outputs are sampled 1ns after the edge.
   task automatic beat(input logic rv, input logic [31:0] rd, input logic [31:0] xm,
                       input logic drop);
      ref_valid = rv;
      ref_data  = rd;
      uut_valid = hv2 & ~drop;
      uut_data  = hd2 ^ xm;
      hv2 = hv1;
      hd2 = hd1;
      hv1 = rv;
      hd1 = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic nbeat(input logic [31:0] xm, input logic drop);
      beat(1'b1, pat(k), xm, drop);
      k++;
   endtask

   task automatic chk_all_zero(input string p);
      chk({p, " A.err"},   32'(a_err),   0);
      chk({p, " A.state"}, 32'(a_state), 0);
      chk({p, " A.mcnt"},  32'(a_mcnt),  0);
      chk({p, " A.ccnt"},  32'(a_ccnt),  0);
      chk({p, " A.kind"},  32'(a_kind),  0);
      chk({p, " A.chan"},  32'(a_chan),  0);
      chk({p, " A.fref"},  32'(a_fref),  0);
      chk({p, " A.fuut"},  32'(a_fuut),  0);
      chk({p, " A.fcyc"},  32'(a_fcyc),  0);
      chk({p, " B.err"},   32'(b_err),   0);
      chk({p, " B.state"}, 32'(b_state), 0);
      chk({p, " B.mcnt"},  32'(b_mcnt),  0);
      chk({p, " B.ccnt"},  32'(b_ccnt),  0);
      chk({p, " B.kind"},  32'(b_kind),  0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0;
      ref_valid = 1'b0; uut_valid = 1'b0; ref_data = '0; uut_data = '0;
      for (int i = 0; i < 3; i++) beat(1'b0, 32'h0, 32'h0, 1'b0);
      chk_all_zero("reset");

      // Identical streams with periodic bubbles: 3 cycles lost to disabled+warm-up.
      rst_n = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         beat((i % 7) != 6, pat(k), 32'h0, 1'b0);
         k++;
      end
      chk("clean A.err",   32'(a_err),   0);
      chk("clean A.mcnt",  32'(a_mcnt),  0);
      chk("clean A.state", 32'(a_state), 2);
      chk("clean A.ccnt",  32'(a_ccnt),  97);
      chk("clean B.ccnt",  32'(b_ccnt),  97);

      // ch2 carries 0x5B on ref and 0x5A on uut.
      beat(1'b1, 32'h115B3344, 32'h0, 1'b0);
      nbeat(32'h0, 1'b0);
      nbeat(32'h0001_0000, 1'b0);
      chk("ch2 A.err",   32'(a_err),   1);
      chk("ch2 A.state", 32'(a_state), 3);
      chk("ch2 A.kind",  32'(a_kind),  2);
      chk("ch2 A.chan",  32'(a_chan),  2);
      chk("ch2 A.fref",  32'(a_fref),  32'h5B);
      chk("ch2 A.fuut",  32'(a_fuut),  32'h5A);
      chk("ch2 A.fcyc",  32'(a_fcyc),  99);
      chk("ch2 A.mcnt",  32'(a_mcnt),  1);
      chk("ch2 B.mcnt",  32'(b_mcnt),  1);
      chk("ch2 B.state", 32'(b_state), 2);
      for (int i = 0; i < 3; i++) nbeat(32'h0, 1'b0);
      chk("failed A.ccnt held", 32'(a_ccnt),  100);
      chk("failed A.state",     32'(a_state), 3);
      chk("running B.ccnt",     32'(b_ccnt),  103);

      // clr lands on a cycle where B would otherwise see a ch1 mismatch.
      clr = 1'b1;
      nbeat(32'h0000_0100, 1'b0);
      clr = 1'b0;
      chk("clr B.err",   32'(b_err),   0);
      chk("clr B.mcnt",  32'(b_mcnt),  0);
      chk("clr B.ccnt",  32'(b_ccnt),  0);
      chk("clr B.kind",  32'(b_kind),  0);
      chk("clr B.state", 32'(b_state), 1);
      chk("clr A.state", 32'(a_state), 1);
      chk("clr A.err",   32'(a_err),   0);
      nbeat(32'h0, 1'b0);
      chk("clr+1 B.state", 32'(b_state), 1);
      nbeat(32'h0, 1'b0);
      chk("clr+2 B.state", 32'(b_state), 2);
      chk("clr+2 A.state", 32'(a_state), 2);

      // Three beats corrupted on ch1 and ch3 after three clean compares.
      for (int i = 0; i < 3; i++) nbeat(32'h0, 1'b0);
      exp_ref = hd2[15:8];
      for (int i = 0; i < 3; i++) nbeat(32'h0100_0100, 1'b0);
      chk("multi B.mcnt", 32'(b_mcnt), 3);
      chk("multi B.ccnt", 32'(b_ccnt), 6);
      chk("multi B.kind", 32'(b_kind), 2);
      chk("multi B.chan", 32'(b_chan), 1);
      chk("multi B.fref", 32'(b_fref), 32'(exp_ref));
      chk("multi B.fuut", 32'(b_fuut), 32'(exp_ref ^ 8'h01));
      chk("multi B.fcyc", 32'(b_fcyc), 3);
      chk("multi A.mcnt", 32'(a_mcnt), 1);
      chk("multi A.chan", 32'(a_chan), 1);

      // ch0 corruption is invisible to B, then a dropped uut valid.
      clr = 1'b1;
      nbeat(32'h0, 1'b0);
      clr = 1'b0;
      for (int i = 0; i < 4; i++) nbeat(32'h0, 1'b0);
      nbeat(32'h0000_00FF, 1'b0);
      chk("mask B.err",  32'(b_err),  0);
      chk("mask B.mcnt", 32'(b_mcnt), 0);
      chk("mask A.kind", 32'(a_kind), 2);
      chk("mask A.chan", 32'(a_chan), 0);
      nbeat(32'h0, 1'b1);
      chk("vld B.err",  32'(b_err),  1);
      chk("vld B.kind", 32'(b_kind), 1);
      chk("vld B.chan", 32'(b_chan), 0);
      chk("vld B.fcyc", 32'(b_fcyc), 3);
      chk("vld B.mcnt", 32'(b_mcnt), 1);

      // en low mid-stream holds counters; resume must not flag anything.
      en = 1'b0;
      for (int i = 0; i < 3; i++) nbeat(32'h0, 1'b0);
      chk("en0 B.state", 32'(b_state), 0);
      chk("en0 B.ccnt",  32'(b_ccnt),  4);
      chk("en0 B.err",   32'(b_err),   1);
      en = 1'b1;
      for (int i = 0; i < 10; i++) nbeat(32'h0, 1'b0);
      chk("resume B.state", 32'(b_state), 2);
      chk("resume B.mcnt",  32'(b_mcnt),  1);
      chk("resume B.ccnt",  32'(b_ccnt),  11);
      chk("resume A.mcnt",  32'(a_mcnt),  1);
      chk("resume A.ccnt",  32'(a_ccnt),  10);

      // Asynchronous reset pulse mid-run.
      rst_n = 1'b0;
      #2;
      chk_all_zero("rstpulse");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) nbeat(32'h0, 1'b0);
      chk("post-rst A.state", 32'(a_state), 2);
      chk("post-rst A.err",   32'(a_err),   0);
      chk("post-rst B.mcnt",  32'(b_mcnt),  0);
      chk("post-rst B.ccnt",  32'(b_ccnt),  7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
